// File: rtl/sram_ctrl_pkg.sv
// Shared widths and requester tag types for the SRAM port-0 arbiter.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_WIDTH  = 9;
  localparam int SRAM_DATA_WIDTH  = 32;
  localparam int SRAM_WMASK_WIDTH = 4;

  typedef enum logic {
    RID_0 = 1'b0,
    RID_1 = 1'b1
  } req_id_e;

  // One stage of the response-routing pipeline.
  typedef struct packed {
    logic    vld;
    req_id_e id;
    logic    we;
  } rsp_tag_t;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way grant selection: round-robin when SRAM_ARB_RR_EN is defined,
// otherwise fixed priority with requester 0 winning and no pointer state.
module sram_rr_arbiter
  import sram_ctrl_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef SRAM_ARB_RR_EN
  req_id_e prio;  // requester favoured on the next tie

  always_ff @(posedge clk) begin
    if (rst)           prio <= RID_0;
    else if (grant[0]) prio <= RID_1;
    else if (grant[1]) prio <= RID_0;
  end

  always_comb begin
    // NOTE: assign every always_comb output first so no path leaves it unassigned (no latch).
    grant = '0;
    if (req == 2'b11) grant = (prio == RID_1) ? 2'b10 : 2'b01;
    else              grant = req;
  end
`else
  assign grant = req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
`endif

endmodule

// File: rtl/sram_port0_arbiter.sv
// Two-requester arbiter for SRAM macro port 0 with fixed two-cycle response latency.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration (default fixed priority).
module sram_port0_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int NUM_WMASKS = SRAM_WMASK_WIDTH
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,

  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [NUM_WMASKS-1:0] r0_wmask,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rsp_valid,
  output logic [DATA_WIDTH-1:0] r0_rdata,

  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [NUM_WMASKS-1:0] r1_wmask,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rsp_valid,
  output logic [DATA_WIDTH-1:0] r1_rdata,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  logic [1:0]            req;
  logic [1:0]            grant;
  logic                  accept;
  req_id_e               sel_id;
  logic                  sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rsp_tag_t              tag1;
  rsp_tag_t              tag2;
  logic [1:0]            rsp_vld_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

  assign req = {r1_valid, r0_valid};

  sram_rr_arbiter u_arb (
`ifdef SRAM_ARB_RR_EN
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
`endif
    .req   (req),
    .grant (grant)
  );

  // Grant is already qualified by valid; reset only has to mask it.
  assign r0_ready = grant[0] & ~wb_rst_i;
  assign r1_ready = grant[1] & ~wb_rst_i;
  assign accept   = r0_ready | r1_ready;

  assign sel_id    = grant[1] ? RID_1 : RID_0;
  assign sel_we    = (sel_id == RID_1) ? r1_we    : r0_we;
  assign sel_wmask = (sel_id == RID_1) ? r1_wmask : r0_wmask;
  assign sel_addr  = (sel_id == RID_1) ? r1_addr  : r0_addr;
  assign sel_wdata = (sel_id == RID_1) ? r1_wdata : r0_wdata;

  // Macro inputs are registered; address and data hold while idle.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (wb_rst_i) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else if (accept) begin
      sram_csb0   <= 1'b0;
      sram_web0   <= ~sel_we;
      sram_wmask0 <= sel_wmask;
      sram_addr0  <= sel_addr;
      sram_din0   <= sel_wdata;
    end else begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
    end
  end

  // Tag pipeline: stage 1 matches the macro input cycle, stage 2 the dout cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      tag1 <= '{vld: accept, id: sel_id, we: sel_we};
      tag2 <= tag1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rsp_vld_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rsp_vld_q <= '0;
      if (tag2.vld) begin
        if (tag2.id == RID_1) begin
          rsp_vld_q[1] <= 1'b1;
          if (!tag2.we) rdata1_q <= sram_dout0;
        end else begin
          rsp_vld_q[0] <= 1'b1;
          if (!tag2.we) rdata0_q <= sram_dout0;
        end
      end
    end
  end

  assign r0_rsp_valid = rsp_vld_q[0] & ~wb_rst_i;
  assign r1_rsp_valid = rsp_vld_q[1] & ~wb_rst_i;
  assign r0_rdata     = wb_rst_i ? '0 : rdata0_q;
  assign r1_rdata     = wb_rst_i ? '0 : rdata1_q;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Scoreboard bench for sram_port0_arbiter with a behavioural port-0 SRAM macro;
// contention expectations follow SRAM_ARB_RR_EN.
module tb_sram_port0_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        r0_valid, r0_ready, r0_we, r0_rsp_valid;
  logic [3:0]  r0_wmask;
  logic [8:0]  r0_addr;
  logic [31:0] r0_wdata, r0_rdata;
  logic        r1_valid, r1_ready, r1_we, r1_rsp_valid;
  logic [3:0]  r1_wmask;
  logic [8:0]  r1_addr;
  logic [31:0] r1_wdata, r1_rdata;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [3:0]  mask;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } rq_t;

  typedef struct {
    int          due;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] last_rd [2] = '{32'h0, 32'h0};
  logic [31:0] mem [512];

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Behavioural macro: samples its inputs on the rising edge, dout valid after that edge.
  always @(posedge wb_clk_i) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  sram_port0_arbiter dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .r0_valid     (r0_valid),
    .r0_ready     (r0_ready),
    .r0_we        (r0_we),
    .r0_wmask     (r0_wmask),
    .r0_addr      (r0_addr),
    .r0_wdata     (r0_wdata),
    .r0_rsp_valid (r0_rsp_valid),
    .r0_rdata     (r0_rdata),
    .r1_valid     (r1_valid),
    .r1_ready     (r1_ready),
    .r1_we        (r1_we),
    .r1_wmask     (r1_wmask),
    .r1_addr      (r1_addr),
    .r1_wdata     (r1_wdata),
    .r1_rsp_valid (r1_rsp_valid),
    .r1_rdata     (r1_rdata),
    .sram_csb0    (sram_csb0),
    .sram_web0    (sram_web0),
    .sram_wmask0  (sram_wmask0),
    .sram_addr0   (sram_addr0),
    .sram_din0    (sram_din0),
    .sram_dout0   (sram_dout0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rq_t wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
    return '{valid: 1'b1, we: 1'b1, mask: m, addr: a, wdata: d};
  endfunction

  function automatic rq_t rd(input logic [8:0] a);
    return '{valid: 1'b1, we: 1'b0, mask: 4'h0, addr: a, wdata: 32'h0};
  endfunction

  function automatic rq_t idle();
    return '0;
  endfunction

  function automatic int sb_size(input int i);
    return (i == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic int sb_front_due(input int i);
    return (i == 0) ? sb0[0].due : sb1[0].due;
  endfunction

  function automatic exp_t sb_pop(input int i);
    return (i == 0) ? sb0.pop_front() : sb1.pop_front();
  endfunction

  // One clock of stimulus; eg is the hand-computed grant, ersp whether a response is owed.
  task automatic step(input rq_t a, input rq_t b, input logic rst, input logic [1:0] eg,
                      input logic ersp, input logic [31:0] erd);
    exp_t e;
    @(negedge wb_clk_i);
    wb_rst_i = rst;
    r0_valid = a.valid; r0_we = a.we; r0_wmask = a.mask; r0_addr = a.addr; r0_wdata = a.wdata;
    r1_valid = b.valid; r1_we = b.we; r1_wmask = b.mask; r1_addr = b.addr; r1_wdata = b.wdata;
    #1;
    check("r0_ready", r0_ready, eg[0]);
    check("r1_ready", r1_ready, eg[1]);
    if (ersp && eg != 2'b00) begin
      e.due  = cyc + 3;
      e.we   = eg[1] ? b.we : a.we;
      e.data = erd;
      if (eg[1]) sb1.push_back(e);
      else       sb0.push_back(e);
    end
  endtask

  task automatic check_port(input logic csb, input logic web, input logic [3:0] m,
                            input logic [8:0] a, input logic [31:0] d);
    check("sram_csb0", sram_csb0, csb);
    check("sram_web0", sram_web0, web);
    check("sram_wmask0", sram_wmask0, m);
    check("sram_addr0", sram_addr0, a);
    check("sram_din0", sram_din0, d);
  endtask

  task automatic check_reset_outputs();
    check_port(1'b1, 1'b1, 4'h0, 9'h0, 32'h0);
    check("r0_rsp_valid in reset", r0_rsp_valid, 0);
    check("r1_rsp_valid in reset", r1_rsp_valid, 0);
    check("r0_rdata in reset", r0_rdata, 0);
    check("r1_rdata in reset", r1_rdata, 0);
  endtask

  task automatic mon_port(input int i, input logic vld, input logic [31:0] rdat);
    exp_t e;
    if (vld) begin
      if (sb_size(i) == 0) begin
        check($sformatf("r%0d_rsp_valid unexpected", i), vld, 0);
      end else begin
        e = sb_pop(i);
        check($sformatf("r%0d response cycle", i), cyc, e.due);
        if (e.we) begin
          check($sformatf("r%0d_rdata held on write ack", i), rdat, last_rd[i]);
        end else begin
          check($sformatf("r%0d_rdata", i), rdat, e.data);
          last_rd[i] = e.data;
        end
      end
    end else if (sb_size(i) != 0 && sb_front_due(i) <= cyc) begin
      check($sformatf("r%0d_rsp_valid missing", i), vld, 1);
      void'(sb_pop(i));
    end
  endtask

  // Monitor samples after the driver has settled on the same falling edge.
  always @(negedge wb_clk_i) begin
    #2;
    if (wb_rst_i) begin
      last_rd[0] = '0;
      last_rd[1] = '0;
    end
    mon_port(0, r0_rsp_valid, r0_rdata);
    mon_port(1, r1_rsp_valid, r1_rdata);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wb_rst_i = 1'b1;
    r0_valid = 0; r0_we = 0; r0_wmask = '0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 0; r1_we = 0; r1_wmask = '0; r1_addr = '0; r1_wdata = '0;

    step(idle(), idle(), 1'b1, 2'b00, 1'b0, 32'h0);
    step(idle(), idle(), 1'b1, 2'b00, 1'b0, 32'h0);
    check_reset_outputs();

    // Write then read back; first acceptance right after reset release.
    step(wr(9'h010, 32'hDEADBEEF, 4'hF), idle(), 1'b0, 2'b01, 1'b1, 32'h0);
    step(rd(9'h010), idle(), 1'b0, 2'b01, 1'b1, 32'hDEADBEEF);

    // Back-to-back write/read of the same word.
    step(wr(9'h0A5, 32'h5A5A5A5A, 4'hF), idle(), 1'b0, 2'b01, 1'b1, 32'h0);
    step(rd(9'h0A5), idle(), 1'b0, 2'b01, 1'b1, 32'h5A5A5A5A);

    // Zero-mask write is acknowledged but leaves memory untouched.
    step(wr(9'h010, 32'hFFFFFFFF, 4'h0), idle(), 1'b0, 2'b01, 1'b1, 32'h0);
    step(rd(9'h010), idle(), 1'b0, 2'b01, 1'b1, 32'hDEADBEEF);

    // Byte-masked overwrite from requester 1 alone.
    step(idle(), wr(9'h020, 32'h11223344, 4'hF), 1'b0, 2'b10, 1'b1, 32'h0);
    step(idle(), wr(9'h020, 32'hAABBCCDD, 4'h5), 1'b0, 2'b10, 1'b1, 32'h0);
    step(idle(), rd(9'h020), 1'b0, 2'b10, 1'b1, 32'h11BB33DD);
    check_port(1'b0, 1'b0, 4'h5, 9'h020, 32'hAABBCCDD);

    // Both requesters valid for four cycles; last acceptance was requester 1.
`ifdef SRAM_ARB_RR_EN
    step(rd(9'h010), rd(9'h020), 1'b0, 2'b01, 1'b1, 32'hDEADBEEF);
    step(rd(9'h010), rd(9'h020), 1'b0, 2'b10, 1'b1, 32'h11BB33DD);
    step(rd(9'h010), rd(9'h020), 1'b0, 2'b01, 1'b1, 32'hDEADBEEF);
    step(rd(9'h010), rd(9'h020), 1'b0, 2'b10, 1'b1, 32'h11BB33DD);
`else
    for (int k = 0; k < 4; k++)
      step(rd(9'h010), rd(9'h020), 1'b0, 2'b01, 1'b1, 32'hDEADBEEF);
`endif
    for (int k = 0; k < 4; k++) step(idle(), idle(), 1'b0, 2'b00, 1'b0, 32'h0);

    // Reset one cycle after a read accept: the response must be discarded.
    step(rd(9'h010), idle(), 1'b0, 2'b01, 1'b0, 32'h0);
    step(rd(9'h010), idle(), 1'b1, 2'b00, 1'b0, 32'h0);
    step(idle(), idle(), 1'b1, 2'b00, 1'b0, 32'h0);
    check_reset_outputs();
    step(rd(9'h0A5), idle(), 1'b0, 2'b01, 1'b1, 32'h5A5A5A5A);
    for (int k = 0; k < 4; k++) step(idle(), idle(), 1'b0, 2'b00, 1'b0, 32'h0);
    check_port(1'b1, 1'b1, 4'h0, 9'h0A5, 32'h0);

    check("r0 responses outstanding", sb0.size(), 0);
    check("r1 responses outstanding", sb1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_port0_arbiter.md
SRAM_PORT0_ARBITER -- requirements
Module: sram_port0_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9: word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width.
REQ-003 SHALL have parameter NUM_WMASKS, default 4: byte-lane write-mask width.
REQ-004 SHALL have port wb_clk_i  in  1: the only clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i  in  1: synchronous, active-high reset.
REQ-006 SHALL have ports rN_valid  in  1 (N=0,1): requester N has a request.
REQ-007 SHALL have ports rN_ready  out  1: request accepted this cycle.
REQ-008 SHALL have ports rN_we  in  1: 1=write, 0=read.
REQ-009 SHALL have ports rN_wmask  in  NUM_WMASKS: byte-lane enables for writes.
REQ-010 SHALL have ports rN_addr  in  ADDR_WIDTH: word address.
REQ-011 SHALL have ports rN_wdata  in  DATA_WIDTH: write data.
REQ-012 SHALL have ports rN_rsp_valid  out  1: one-cycle response strobe.
REQ-013 SHALL have ports rN_rdata  out  DATA_WIDTH: read data.
REQ-014 SHALL have ports sram_csb0  out  1 / sram_web0  out  1: active-low macro select and write enable, registered.
REQ-015 SHALL have ports sram_wmask0  out  NUM_WMASKS / sram_addr0  out  ADDR_WIDTH / sram_din0  out  DATA_WIDTH: registered macro port-0 inputs.
REQ-016 SHALL have port sram_dout0  in  DATA_WIDTH: macro port-0 read data.

Function
REQ-017 SHALL grant at most one requester per cycle; rN_ready = rN_valid AND granted to N (combinational from valid); acceptance = valid & ready at a rising edge.
REQ-018 SHALL, on acceptance at edge E0, drive csb0=0, web0=~we, wmask0, addr0, din0 from edge E0 until the next edge; with no acceptance, drive csb0=1, web0=1, wmask0=0, other outputs held.
REQ-019 SHALL capture sram_dout0 at edge E2 for an accepted read and assert rN_rsp_valid for exactly the cycle after E2 (fixed two-cycle latency).
REQ-020 SHALL acknowledge an accepted write with rN_rsp_valid in the same cycle a read would respond; rN_rdata SHALL hold its previous value on write acks.
REQ-021 SHALL sustain one acceptance per cycle, with responses in acceptance order; a two-deep requester-ID/valid/we pipeline routes each response to its originator only.
REQ-022 SHALL give, for a write accepted at E0 followed by a read of the same address at E1, read data equal to the new data, with no forwarding logic.
REQ-023 SHALL not support response backpressure; requesters SHALL always accept rsp_valid.
REQ-024 SHALL treat a write with wmask=0 as a legal no-op access that still returns an ack.
REQ-025 SHALL, with only one requester valid, grant it regardless of priority state.

Reset
REQ-026 SHALL, while wb_rst_i=1, force rN_ready=0, rN_rsp_valid=0, rN_rdata=0, csb0=1, web0=1, wmask0=0, addr0=0, din0=0, and the priority pointer to "requester 0 next".
REQ-027 SHALL, on reset asserted mid-operation, discard all in-flight responses; no rsp_valid SHALL appear for requests accepted before reset.
REQ-028 SHALL allow acceptance at the first edge after wb_rst_i deasserts.

Configuration
REQ-029 SHALL, with SRAM_ARB_RR_EN defined, arbitrate round-robin: on simultaneous valid, grant the requester not granted most recently; the pointer updates only on acceptance.
REQ-030 SHALL, without SRAM_ARB_RR_EN, use fixed priority with requester 0 always winning, and no pointer state.

Structure
REQ-031 SHALL place ADDR/DATA/WMASK width constants and the requester-ID type in shared package sram_ctrl_pkg.
REQ-032 SHALL implement grant selection in one sub-module, sram_rr_arbiter (2-way, RR or fixed per the macro).

Verification
REQ-033 SHALL verify: r0 write addr 0x010 data 0xDEADBEEF mask 0xF, then r0 read 0x010 -> r0_rsp_valid two cycles after each accept, rdata=0xDEADBEEF.
REQ-034 SHALL verify: write 0x11223344 mask 0xF, then write 0xAABBCCDD mask 0x5 to the same address, then read -> 0x11BB33DD.
REQ-035 SHALL verify: r0 and r1 both valid for 4 cycles (RR build) -> grants alternate 0,1,0,1, and each rsp_valid reaches only its originator.
REQ-036 SHALL verify: same stimulus in the fixed build -> r0 granted 4 times, r1_ready=0 throughout.
REQ-037 SHALL verify: back-to-back write 0x0A5=0x5A5A5A5A then read 0x0A5 on consecutive cycles -> read returns 0x5A5A5A5A.
REQ-038 SHALL verify: reset asserted one cycle after a read accept -> no rsp_valid, csb0=1, all outputs at reset values.
